filter_conv_kxk_pipe: RTL and testbench

//  Pipelined, parametrised KSIZE x KSIZE signed-coefficient convolution for the image filter path.

---
 rtl/filter_conv_kxk_pipe.sv | 140 ++++++++++++++
 tb/tb_filter_conv_kxk_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_conv_kxk_pipe.sv
// filter_conv_kxk_pipe
//   Pipelined KSIZE x KSIZE signed-coefficient convolution with saturated output.
//   Stages: registered products, $clog2(N) registered adder-tree levels,
//   registered shift/saturate. Coefficients live in a double-buffered bank
//   (serial shadow writes, atomic commit to the active bank).
//   Optional macro FILTER_CONV_ROUND_EN: round-half-up before the right shift.
module filter_conv_kxk_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int COEF_WIDTH = 8,
   parameter int KSIZE      = 5,
   parameter int SHIFT_W    = 5
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                i_en,
   input  logic                                i_valid,
   input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   i_win,
   input  logic [SHIFT_W-1:0]                  i_shift,
   input  logic                                i_coef_we,
   input  logic [$clog2(KSIZE*KSIZE)-1:0]      i_coef_addr,
   input  logic [COEF_WIDTH-1:0]               i_coef_data,
   input  logic                                i_coef_commit,
   output logic                                o_valid,
   output logic [DATA_WIDTH-1:0]               o_y,
   output logic                                o_sat
);

   localparam int N    = KSIZE * KSIZE;
   localparam int LOG  = $clog2(N);
   localparam int NP   = 1 << LOG;          // leaves padded to a power of two
   localparam int PW   = DATA_WIDTH + COEF_WIDTH + 1;
   localparam int AW   = PW + LOG;
   localparam int ADW  = $clog2(N);
   localparam int ROOT = 2 * NP - 2;        // tree nodes stored level by level
   localparam logic signed [AW:0] YMAX = (AW+1)'((1 << DATA_WIDTH) - 1);

   logic signed [COEF_WIDTH-1:0] shadow_q [N];
   logic signed [COEF_WIDTH-1:0] shadow_d [N];
   logic signed [COEF_WIDTH-1:0] active_q [N];
   logic signed [PW-1:0]         prod_d   [N];
   logic signed [AW-1:0]         node_q   [2*NP-1];
   logic [LOG:0]                 vld_pipe_q;
   logic [SHIFT_W-1:0]           sh_q     [LOG+1];
   logic signed [AW-1:0]         acc;
   logic signed [AW:0]           res_d;
   logic [DATA_WIDTH-1:0]        y_q, y_d;
   logic                         sat_q, sat_d, valid_q;

   // Shadow bank next state: one serial write per cycle, out-of-range addresses dropped
   always_comb begin
      for (int i = 0; i < N; i++) begin
         shadow_d[i] = shadow_q[i];
         if (i_coef_we && i_coef_addr == ADW'(i)) shadow_d[i] = i_coef_data;
      end
   end

   // Coefficient banks run off i_en; commit takes the shadow including a same-cycle write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
         if (i_coef_commit) active_q <= shadow_d;
      end
   end

   // Per-tap product: pixel zero-extended to a signed DATA_WIDTH+1 value times coefficient
   always_comb begin
      for (int i = 0; i < N; i++)
         prod_d[i] = PW'($signed({1'b0, i_win[i*DATA_WIDTH +: DATA_WIDTH]})) * PW'(active_q[i]);
   end

   assign acc = node_q[ROOT];

   // Final stage: shift (optionally rounded) then clamp to the unsigned pixel range
   always_comb begin
`ifdef FILTER_CONV_ROUND_EN
      // with shift >= AW the bias dominates any accumulator value, result is exactly 0
      if (int'(sh_q[LOG]) >= AW)
         res_d = '0;
      else if (sh_q[LOG] == '0)
         res_d = (AW+1)'(acc);
      else
         res_d = ((AW+1)'(acc) + ((AW+1)'(1) << (sh_q[LOG] - 1'b1))) >>> sh_q[LOG];
`else
      if (int'(sh_q[LOG]) >= AW)
         res_d = {(AW+1){acc[AW-1]}};
      else
         res_d = (AW+1)'(acc >>> sh_q[LOG]);
`endif
      y_d   = y_q;
      sat_d = sat_q;
      if (vld_pipe_q[LOG]) begin
         if (res_d < 0) begin
            y_d   = '0;
            sat_d = 1'b1;
         end else if (res_d > YMAX) begin
            y_d   = '1;
            sat_d = 1'b1;
         end else begin
            y_d   = res_d[DATA_WIDTH-1:0];
            sat_d = 1'b0;
         end
      end
   end

   // Datapath pipeline: every stage advances together on i_en and holds otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
         valid_q    <= 1'b0;
         y_q        <= '0;
         sat_q      <= 1'b0;
         for (int l = 0; l <= LOG; l++) sh_q[l] <= '0;
         for (int j = 0; j < 2*NP-1; j++) node_q[j] <= '0;
      end else if (i_en) begin
         vld_pipe_q <= {vld_pipe_q[LOG-1:0], i_valid};
         sh_q[0]    <= i_shift;
         for (int l = 1; l <= LOG; l++) sh_q[l] <= sh_q[l-1];
         for (int j = 0; j < N; j++)  node_q[j] <= AW'(prod_d[j]);
         for (int j = N; j < NP; j++) node_q[j] <= '0;
         for (int l = 1; l <= LOG; l++)
            for (int j = 0; j < (NP >> l); j++)
               node_q[2*NP - ((2*NP) >> l) + j] <=
                  node_q[2*NP - ((2*NP) >> (l-1)) + 2*j] +
                  node_q[2*NP - ((2*NP) >> (l-1)) + 2*j + 1];
         valid_q <= vld_pipe_q[LOG];
         y_q     <= y_d;
         sat_q   <= sat_d;
      end
   end

   assign o_valid = valid_q;
   assign o_y     = y_q;
   assign o_sat   = sat_q;

endmodule

// File: tb/tb_filter_conv_kxk_pipe.sv
// Bench for filter_conv_kxk_pipe: directed table, commit/stall/reset sequences,
// randomized traffic against an arithmetic reference model, and a KSIZE=3 instance.
module tb_filter_conv_kxk_pipe;
   localparam int DW = 8, CW = 8, SW = 5;
   localparam int N = 25, ADW = 5, LAT = 7;
   localparam int N3 = 9, ADW3 = 4, LAT3 = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic en, valid, we, commit;
   logic [N*DW-1:0] win;
   logic [SW-1:0] shift;
   logic [ADW-1:0] addr;
   logic [CW-1:0] data;
   logic o_valid, o_sat;
   logic [DW-1:0] o_y;

   logic en3, valid3, we3, commit3;
   logic [N3*DW-1:0] win3;
   logic [SW-1:0] shift3;
   logic [ADW3-1:0] addr3;
   logic [CW-1:0] data3;
   logic ov3, os3;
   logic [DW-1:0] oy3;

   filter_conv_kxk_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .KSIZE(5), .SHIFT_W(SW)) u_dut (
      .clk(clk), .rst(rst), .i_en(en), .i_valid(valid), .i_win(win), .i_shift(shift),
      .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(data), .i_coef_commit(commit),
      .o_valid(o_valid), .o_y(o_y), .o_sat(o_sat));

   filter_conv_kxk_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .KSIZE(3), .SHIFT_W(SW)) u_dut3 (
      .clk(clk), .rst(rst), .i_en(en3), .i_valid(valid3), .i_win(win3), .i_shift(shift3),
      .i_coef_we(we3), .i_coef_addr(addr3), .i_coef_data(data3), .i_coef_commit(commit3),
      .o_valid(ov3), .o_y(oy3), .o_sat(os3));

   int n_tests = 0, n_fail = 0;
   typedef struct {int y; int sat; int e0;} exp_t;
   exp_t q[$];
   int m_sh[N], m_act[N];
   int en_cnt = 0;
   int last_y = 0, last_sat = 0, pv = 0, py = 0, ps = 0;
   logic got;
   int got_y, got_sat;

   typedef struct {int c; int o; int p; int s; int y; int sat;} vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: sum of pixel*coef, floor(acc / 2^s) (optionally +half), clamp to 0..255
   function automatic void model(input logic [N*DW-1:0] w, input int s, output int y, output int sat);
      longint acc, r;
      acc = 0;
      for (int i = 0; i < N; i++) acc += longint'(w[i*DW +: DW]) * longint'(m_act[i]);
`ifdef FILTER_CONV_ROUND_EN
      if (s > 0) acc += longint'(1) << (s - 1);
`endif
      r = acc >>> s;
      if (r < 0) begin y = 0; sat = 1; end
      else if (r > 255) begin y = 255; sat = 1; end
      else begin y = int'(r); sat = 0; end
   endfunction

   function automatic logic [N*DW-1:0] flat(input int p);
      logic [N*DW-1:0] w;
      for (int i = 0; i < N; i++) w[i*DW +: DW] = p[DW-1:0];
      return w;
   endfunction

   function automatic logic [N*DW-1:0] rwin();
      logic [N*DW-1:0] w;
      for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'($urandom_range(0, 255));
      return w;
   endfunction

   // One clock of the KSIZE=5 DUT, with scoreboard and hold checks after the edge
   task automatic cyc(input logic e, input logic v, input logic [N*DW-1:0] w, input int s,
                      input logic cwe, input int ca, input int cd, input logic cc);
      int y, sat;
      exp_t x;
      en = e; valid = v; win = w; shift = s[SW-1:0];
      we = cwe; addr = ca[ADW-1:0]; data = cd[CW-1:0]; commit = cc;
      if (e && v) begin
         model(w, s, y, sat);
         q.push_back('{y, sat, en_cnt});
      end
      if (cwe && ca < N) m_sh[ca] = cd;
      if (cc) m_act = m_sh;
      @(posedge clk); #1;
      got = 1'b0;
      if (e) begin
         en_cnt++;
         if (o_valid) begin
            if (q.size() == 0) chk("spurious_valid", int'(o_valid), 0);
            else begin
               x = q.pop_front();
               chk("y", int'(o_y), x.y);
               chk("sat", int'(o_sat), x.sat);
               chk("latency", en_cnt - x.e0, LAT);
               got = 1'b1; got_y = int'(o_y); got_sat = int'(o_sat);
               last_y = got_y; last_sat = got_sat;
            end
         end else begin
            chk("bubble_hold_y", int'(o_y), last_y);
            chk("bubble_hold_sat", int'(o_sat), last_sat);
            if (q.size() > 0 && en_cnt - q[0].e0 >= LAT) begin
               chk("missing_valid", int'(o_valid), 1);
               void'(q.pop_front());
            end
         end
      end else begin
         chk("stall_valid", int'(o_valid), pv);
         chk("stall_y", int'(o_y), py);
         chk("stall_sat", int'(o_sat), ps);
      end
      pv = int'(o_valid); py = int'(o_y); ps = int'(o_sat);
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, '0, 0, 1'b0, 0, 0, 1'b0);
   endtask

   // Whole bank: centre tap c, others o; centre written together with commit
   task automatic prog(input int c, input int o);
      for (int a = 0; a < N; a++)
         if (a != 12) cyc(1'b1, 1'b0, '0, 0, 1'b1, a, o, 1'b0);
      cyc(1'b1, 1'b0, '0, 0, 1'b1, 12, c, 1'b1);
   endtask

   task automatic do_reset();
      valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_y", int'(o_y), 0);
      chk("rst_sat", int'(o_sat), 0);
      q.delete();
      for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      last_y = 0; last_sat = 0; pv = 0; py = 0; ps = 0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // KSIZE=3 directed check: program bank, one window, measure latency and result
   task automatic run3(input int c, input int o, input int p, input int s, input int ey, input int es);
      int n;
      for (int a = 0; a < N3; a++) begin
         we3 = 1'b1; addr3 = a[ADW3-1:0];
         data3 = (a == 4) ? c[CW-1:0] : o[CW-1:0];
         commit3 = (a == N3 - 1);
         @(posedge clk); #1;
      end
      we3 = 1'b0; commit3 = 1'b0;
      for (int i = 0; i < N3; i++) win3[i*DW +: DW] = p[DW-1:0];
      shift3 = s[SW-1:0]; valid3 = 1'b1;
      @(posedge clk); #1;
      valid3 = 1'b0;
      n = 1;
      while (!ov3 && n < 20) begin @(posedge clk); #1; n++; end
      chk("k3_latency", n, LAT3);
      chk("k3_y", int'(oy3), ey);
      chk("k3_sat", int'(os3), es);
   endtask

   initial begin
      int outs[$];
      int n, cnt;
      logic rv;
      rst = 1'b1;
      en = 1'b0; valid = 1'b0; win = '0; shift = '0; we = 1'b0; addr = '0; data = '0; commit = 1'b0;
      en3 = 1'b1; valid3 = 1'b0; win3 = '0; shift3 = '0; we3 = 1'b0; addr3 = '0; data3 = '0; commit3 = 1'b0;
      for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      @(posedge clk); #1;
      chk("init_valid", int'(o_valid), 0);
      chk("init_y", int'(o_y), 0);
      chk("init_sat", int'(o_sat), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed table: {centre, other, pixel, shift, exp_y, exp_sat}
      tbl[0]  = '{64, 0, 100, 6, 100, 0};
      tbl[1]  = '{1, 1, 255, 0, 255, 1};
      tbl[2]  = '{1, 1, 255, 5, 199, 0};
      tbl[3]  = '{-1, 0, 50, 0, 0, 1};
`ifdef FILTER_CONV_ROUND_EN
      tbl[4]  = '{1, 0, 3, 1, 2, 0};
      tbl[9]  = '{-128, -128, 255, 31, 0, 0};
      tbl[11] = '{100, 1, 200, 7, 194, 0};
`else
      tbl[4]  = '{1, 0, 3, 1, 1, 0};
      tbl[9]  = '{-128, -128, 255, 31, 0, 1};
      tbl[11] = '{100, 1, 200, 7, 193, 0};
`endif
      tbl[5]  = '{2, 0, 200, 0, 255, 1};
      tbl[6]  = '{-1, 1, 10, 0, 230, 0};
      tbl[7]  = '{0, 0, 77, 3, 0, 0};
      tbl[8]  = '{127, 127, 255, 31, 0, 0};
      tbl[10] = '{-128, -128, 255, 0, 0, 1};
      for (int i = 0; i < 12; i++) begin
         prog(tbl[i].c, tbl[i].o);
         cyc(1'b1, 1'b1, flat(tbl[i].p), tbl[i].s, 1'b0, 0, 0, 1'b0);
         n = 0;
         while (!got && n < 20) begin idle(); n++; end
         chk("tbl_done", int'(got), 1);
         chk("tbl_y", got_y, tbl[i].y);
         chk("tbl_sat", got_sat, tbl[i].sat);
      end

      // commit timing: shadow rewritten early, commit with window 9 (plus a same-cycle write)
      prog(1, 0);
      outs.delete();
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1, 1'b1, flat(k + 1), 0, (k == 0 || k == 9), (k == 0) ? 12 : 0, (k == 0) ? 2 : 1, (k == 9));
         if (got) outs.push_back(got_y);
      end
      for (int k = 0; k < 12; k++) begin idle(); if (got) outs.push_back(got_y); end
      chk("commit_count", outs.size(), 20);
      for (int k = 0; k < 20 && k < outs.size(); k++)
         chk("commit_win", outs[k], (k < 10) ? (k + 1) : 3 * (k + 1));

      // stall mid-stream: valid ignored while en=0, no sample lost or duplicated
      prog(5, 3);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 5)
            for (int s = 0; s < 3; s++) cyc(1'b0, 1'b1, rwin(), 4, 1'b0, 0, 0, 1'b0);
         cyc(1'b1, 1'b1, rwin(), 4, 1'b0, 0, 0, 1'b0);
         if (got) cnt++;
      end
      for (int k = 0; k < 12; k++) begin idle(); if (got) cnt++; end
      chk("stall_count", cnt, 10);

      // reset mid-stream: banks cleared, so subsequent windows give 0
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, rwin(), 4, 1'b0, 0, 0, 1'b0);
      do_reset();
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         cyc(1'b1, (k < 5), rwin(), 0, 1'b0, 0, 0, 1'b0);
         if (got) begin cnt++; chk("post_rst_y", got_y, 0); chk("post_rst_sat", got_sat, 0); end
      end
      chk("post_rst_count", cnt, 5);

      // randomized traffic with bank writes (incl. out-of-range addresses) and commits
      for (int k = 0; k < 800; k++) begin
         rv = ($urandom_range(0, 9) < 7);
         cyc(($urandom_range(0, 9) < 8), rv, rwin(),
             ($urandom_range(0, 15) == 0) ? $urandom_range(13, 31) : $urandom_range(0, 12),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 31), $urandom_range(0, 255) - 128,
             ($urandom_range(0, 15) == 0));
      end
      for (int k = 0; k < 12; k++) idle();
      chk("drain_empty", q.size(), 0);

      // KSIZE=3 rerun of identity / box / negative
      en = 1'b0;
      run3(64, 0, 100, 6, 100, 0);
      run3(1, 1, 255, 0, 255, 1);
      run3(1, 1, 255, 4, 143, 0);
      run3(-1, 0, 50, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
